// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side controller for a byte-serial UART receiver on bd_clk.
//   It follows frame progress through the receiver's rx_empty status. It
//   captures each completed byte into a DEPTH-entry FIFO, which the consumer
//   drains over valid/ready. It allows the receiver to forward a new byte only
//   while FIFO space exists. A frame watchdog aborts frames that hang.
//
// Ports
//   bd_clk    in   baud-rate clock, rising edge
//   rst       in   synchronous active-high reset
//   rx_empty  in   receiver status: 0 = frame in progress, 1 = idle
//   rx_data   in   receiver byte, valid from the rise of rx_empty
//   rx_fwd    out  forward strobe: high while the FIFO is not full
//   rx_abort  out  receiver abort, high for every cycle in ABORT
//   m_data    out  FIFO head byte
//   m_valid   out  FIFO non-empty
//   m_ready   in   consumer accept
//   level     out  FIFO occupancy 0..DEPTH
//   ovf       out  sticky: a captured byte was dropped because the FIFO was full
//   tmo_err   out  sticky: the frame watchdog fired
//   clr_err   in   clears ovf and tmo_err (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int FRAME_TMO = 12
) (
    input  logic          bd_clk,
    input  logic          rst,
    input  logic          rx_empty,
    input  logic [7:0]    rx_data,
    output logic          rx_fwd,
    output logic          rx_abort,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          tmo_err,
    input  logic          clr_err
);

    localparam int CW = $clog2(FRAME_TMO + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_abort;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic          r_tmo;

    logic w_full;
    logic w_pop;
    logic w_capt;
    logic w_push;
    logic w_drop;
    logic w_tmo_fire;

    assign w_full = (r_level == (AW+1)'(DEPTH));
    // m_valid comes from registered level, so a byte pushed this cycle is
    // never poppable in the same cycle.
    assign w_pop  = (r_level != '0) && m_ready;
    assign w_capt = (r_state == S_CAPT);
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    assign w_push = w_capt && (!w_full || w_pop);
    assign w_drop = w_capt && !w_push;
    assign w_tmo_fire = (r_state == S_RECV) && !rx_empty &&
                        (r_cnt == CW'(FRAME_TMO - 1));

    // ---------------- frame FSM ----------------
    always_ff @(posedge bd_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (!rx_empty) begin
                        r_state <= S_RECV;
                        r_cnt   <= '0;
                    end
                end
                S_RECV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (rx_empty) begin
                        r_state <= S_CAPT;
                    end else if (w_tmo_fire) begin
                        r_state <= S_ABORT;
                        r_abort <= 1'b1;  // registered so it is high on ABORT entry
                    end
                end
                S_CAPT: begin
                    r_state <= S_IDLE;
                end
                default: begin  // S_ABORT
                    // Leave only once the receiver has seen the abort and gone idle.
                    if (rx_empty && r_abort) begin
                        r_state <= S_IDLE;
                        r_abort <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge bd_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rx_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    always_ff @(posedge bd_clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
            if (w_tmo_fire)   r_tmo <= 1'b1;
            else if (clr_err) r_tmo <= 1'b0;
        end
    end

    assign rx_fwd   = !w_full;
    assign rx_abort = r_abort;
    assign m_data   = r_mem[r_rd_ptr];
    assign m_valid  = (r_level != '0);
    assign level    = r_level;
    assign ovf      = r_ovf;
    assign tmo_err  = r_tmo;

endmodule
